control_step_sequencer: RTL and testbench

- Parametrised timing-step generator for the Datapath control unit.
- Produces one-hot T-step strobes (T0..T(NUM_STEPS-1)) plus fetch and status flags, replacing hand-sequenced T0–T5 stepping.
- Adds memory-wait stalls, early instruction termination, single-step and halt modes, a memory-wait timeout and an instruction counter.
- Sits between the instruction decoder (consumer of the steps) and the memory interface (source of mem_ready).

---
 rtl/control_step_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_step_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/control_step_sequencer.sv
// control_step_sequencer
//
// Timing-step generator for the datapath control unit. It produces a one-hot
// T-step strobe per instruction. The first FETCH_STEPS steps form the fetch
// phase. The sequencer stalls while memory data is outstanding, lets the
// decoder end an instruction early, supports single-step and halt modes,
// halts on a memory-wait timeout and counts retired instructions.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   run          start / resume request, level sampled each clock
//   stop         halt request, honoured at the next instruction boundary
//   single_mode  return to IDLE after every instruction
//   step_end     decoder: instruction finishes at the current step
//   mem_read_req current step needs memory data
//   mem_ready    memory data valid this cycle
//   step         one-hot active T-step, zero when not running
//   step_idx     binary index of the active step
//   fetch_phase  high while in a fetch step in RUN
//   running      high in RUN
//   halted       high in HALTED
//   timeout_err  sticky memory-wait timeout flag
//   instr_count  retired instruction count, wraps

module control_step_sequencer #(
    parameter int NUM_STEPS   = 8,
    parameter int FETCH_STEPS = 3,
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         run,
    input  logic                         stop,
    input  logic                         single_mode,
    input  logic                         step_end,
    input  logic                         mem_read_req,
    input  logic                         mem_ready,
    output logic [NUM_STEPS-1:0]         step,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         fetch_phase,
    output logic                         running,
    output logic                         halted,
    output logic                         timeout_err,
    output logic [COUNT_W-1:0]           instr_count
);

    localparam int IDX_W  = $clog2(NUM_STEPS);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    localparam logic [IDX_W-1:0]  FETCH_IDX = IDX_W'(FETCH_STEPS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STEPS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [NUM_STEPS-1:0] STEP_ONE = NUM_STEPS'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]         state, next_state;
    logic [IDX_W-1:0]   next_idx;
    logic               stop_pending, next_stop_pending;
    logic [WAIT_W-1:0]  wait_cnt, next_wait, wait_inc;
    logic [COUNT_W-1:0] next_count;
    logic               next_timeout;
    logic               stall, boundary;

    // A stall always wins over a boundary, so step_end raised while waiting
    // for memory cannot end the instruction.
    assign stall    = mem_read_req && !mem_ready;
    assign boundary = (step_end && (step_idx >= FETCH_IDX)) || (step_idx == LAST_IDX);

    // The wait counter saturates so that, with the timeout disabled, a very
    // long stall cannot wrap it.
    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

    // Next-state logic. All outputs are derived from these next values and
    // registered below.
    always_comb begin
        next_state        = state;
        next_idx          = step_idx;
        next_stop_pending = stop_pending;
        next_wait         = wait_cnt;
        next_count        = instr_count;
        next_timeout      = timeout_err;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    next_state = ST_RUN;
                    next_idx   = '0;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    next_stop_pending = 1'b1;
                end
                if (stall) begin
                    next_wait = wait_inc;
                    if ((MEM_TIMEOUT != 0) && (wait_inc == WAIT_MAX)) begin
                        next_state        = ST_HALTED;
                        next_timeout      = 1'b1;
                        next_wait         = '0;
                        next_idx          = '0;
                        next_stop_pending = 1'b0;
                    end
                end else if (boundary) begin
                    next_count        = instr_count + 1'b1;
                    next_idx          = '0;
                    next_wait         = '0;
                    next_stop_pending = 1'b0;
                    if (stop_pending || stop) begin
                        next_state = ST_HALTED;
                    end else if (single_mode) begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    next_idx  = step_idx + 1'b1;
                    next_wait = '0;
                end
            end

            ST_HALTED: begin
                if (run && !stop) begin
                    next_state   = ST_RUN;
                    next_idx     = '0;
                    next_timeout = 1'b0;
                end
            end

            default: begin
                next_state = ST_IDLE;
                next_idx   = '0;
            end
        endcase
    end

    // State and registered outputs. The one-hot strobe and the flags are
    // decoded from the next state so they line up with step_idx.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= ST_IDLE;
            step_idx     <= '0;
            stop_pending <= 1'b0;
            wait_cnt     <= '0;
            instr_count  <= '0;
            timeout_err  <= 1'b0;
            step         <= '0;
            fetch_phase  <= 1'b0;
            running      <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= next_state;
            step_idx     <= next_idx;
            stop_pending <= next_stop_pending;
            wait_cnt     <= next_wait;
            instr_count  <= next_count;
            timeout_err  <= next_timeout;
            step         <= (next_state == ST_RUN) ? (STEP_ONE << next_idx) : '0;
            fetch_phase  <= (next_state == ST_RUN) && (next_idx < FETCH_IDX);
            running      <= (next_state == ST_RUN);
            halted       <= (next_state == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_control_step_sequencer.sv
// Testbench for control_step_sequencer.
// A driver applies one directed input vector per clock and queues the
// hand-computed response. A monitor pops that response after every rising edge
// and compares it with the DUT outputs. A second instance with a 4-bit counter
// shares the inputs, so the counter wrap can be exercised in few cycles.

module tb_control_step_sequencer;

    typedef struct {
        int idx;
        bit run;
        bit halt;
        bit to;
        int cnt;
    } exp_t;

    logic       clk;
    logic       clr;
    logic       run, stop, single_mode, step_end, mem_read_req, mem_ready;
    logic [7:0] step;
    logic [2:0] step_idx;
    logic       fetch_phase, running, halted, timeout_err;
    logic [15:0] instr_count;

    logic [7:0] s_step;
    logic [2:0] s_step_idx;
    logic       s_fetch_phase, s_running, s_halted, s_timeout_err;
    logic [3:0] s_instr_count;

    int   assertions = 0;
    int   failures   = 0;
    exp_t expq[$];
    exp_t mon_e;

    control_step_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .stop(stop), .single_mode(single_mode),
        .step_end(step_end), .mem_read_req(mem_read_req), .mem_ready(mem_ready),
        .step(step), .step_idx(step_idx), .fetch_phase(fetch_phase),
        .running(running), .halted(halted), .timeout_err(timeout_err),
        .instr_count(instr_count)
    );

    control_step_sequencer #(.COUNT_W(4)) dut_small (
        .clk(clk), .clr(clr), .run(run), .stop(stop), .single_mode(single_mode),
        .step_end(step_end), .mem_read_req(mem_read_req), .mem_ready(mem_ready),
        .step(s_step), .step_idx(s_step_idx), .fetch_phase(s_fetch_phase),
        .running(s_running), .halted(s_halted), .timeout_err(s_timeout_err),
        .instr_count(s_instr_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The step strobe and fetch flag are derived from the expected index. The
    // index itself is only compared in RUN, where it has a defined meaning.
    task automatic checkOutput(input exp_t e);
        logic [7:0] eStep;
        eStep = e.run ? (8'd1 << e.idx) : 8'd0;
        cmp("step", {24'd0, step}, {24'd0, eStep});
        if (e.run) cmp("step_idx", {29'd0, step_idx}, e.idx);
        cmp("fetch_phase", {31'd0, fetch_phase}, {31'd0, (e.run && e.idx < 3)});
        cmp("running", {31'd0, running}, {31'd0, e.run});
        cmp("halted", {31'd0, halted}, {31'd0, e.halt});
        cmp("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
        cmp("instr_count", {16'd0, instr_count}, e.cnt & 32'hFFFF);
        cmp("small_count", {28'd0, s_instr_count}, e.cnt & 32'hF);
    endtask

    // Drive one vector on the falling edge and queue the response expected
    // after the following rising edge.
    task automatic applyStimulus(input bit r, input bit s, input bit sm, input bit se,
                                 input bit mrr, input bit mr, input int eIdx,
                                 input bit eRun, input bit eHalt, input bit eTo,
                                 input int eCnt);
        exp_t e;
        @(negedge clk);
        run = r; stop = s; single_mode = sm; step_end = se;
        mem_read_req = mrr; mem_ready = mr;
        e.idx = eIdx; e.run = eRun; e.halt = eHalt; e.to = eTo; e.cnt = eCnt;
        expq.push_back(e);
    endtask

    // Monitor: one response per clock while out of reset.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (clr && expq.size() > 0) begin
                mon_e = expq.pop_front();
                checkOutput(mon_e);
            end
        end
    end

    initial begin
        exp_t z;
        z.idx = 0; z.run = 0; z.halt = 0; z.to = 0; z.cnt = 0;
        clr = 1'b0;
        run = 0; stop = 0; single_mode = 0; step_end = 0; mem_read_req = 0; mem_ready = 0;

        #12;
        checkOutput(z);
        cmp("reset_step_idx", {29'd0, step_idx}, 0);
        @(negedge clk);
        clr = 1'b1;

        // Plain walk T0..T7, then wrap to T0 with one instruction retired.
        applyStimulus(1,0,0,0,0,0, 0,1,0,0,0);
        for (int i = 1; i < 8; i++) applyStimulus(0,0,0,0,0,0, i,1,0,0,0);
        applyStimulus(0,0,0,0,0,0, 0,1,0,0,1);

        // step_end is ignored in fetch steps and ends the instruction at T4.
        applyStimulus(0,0,0,1,0,0, 1,1,0,0,1);
        applyStimulus(0,0,0,1,0,0, 2,1,0,0,1);
        applyStimulus(0,0,0,1,0,0, 3,1,0,0,1);
        applyStimulus(0,0,0,0,0,0, 4,1,0,0,1);
        applyStimulus(0,0,0,1,0,0, 0,1,0,0,2);

        // Three stall cycles at T1, then a stall at T4 that overrides step_end.
        applyStimulus(0,0,0,0,0,0, 1,1,0,0,2);
        for (int i = 0; i < 3; i++) applyStimulus(0,0,0,1,1,0, 1,1,0,0,2);
        applyStimulus(0,0,0,0,1,1, 2,1,0,0,2);
        applyStimulus(0,0,0,0,0,0, 3,1,0,0,2);
        applyStimulus(0,0,0,0,0,0, 4,1,0,0,2);
        applyStimulus(0,0,0,1,1,0, 4,1,0,0,2);
        applyStimulus(0,0,0,0,1,1, 5,1,0,0,2);
        applyStimulus(0,0,0,0,0,1, 6,1,0,0,2);
        applyStimulus(0,0,0,0,0,0, 7,1,0,0,2);
        applyStimulus(0,0,0,0,0,0, 0,1,0,0,3);

        // Memory-wait timeout after 15 stall cycles, then resume from HALTED.
        applyStimulus(0,0,0,0,0,0, 1,1,0,0,3);
        for (int i = 0; i < 14; i++) applyStimulus(0,0,0,0,1,0, 1,1,0,0,3);
        applyStimulus(0,0,0,0,1,0, 0,0,1,1,3);
        applyStimulus(0,0,0,0,0,0, 0,0,1,1,3);
        applyStimulus(1,1,0,0,0,0, 0,0,1,1,3);
        applyStimulus(1,0,0,0,0,0, 0,1,0,0,3);

        // Stop at T2 completes the instruction before halting.
        applyStimulus(0,0,0,0,0,0, 1,1,0,0,3);
        applyStimulus(0,0,0,0,0,0, 2,1,0,0,3);
        applyStimulus(0,1,0,0,0,0, 3,1,0,0,3);
        for (int i = 4; i < 8; i++) applyStimulus(0,0,0,0,0,0, i,1,0,0,3);
        applyStimulus(0,0,0,0,0,0, 0,0,1,0,4);
        applyStimulus(1,0,0,0,0,0, 0,1,0,0,4);

        // Stop together with an early boundary at T3.
        applyStimulus(0,0,0,0,0,0, 1,1,0,0,4);
        applyStimulus(0,0,0,0,0,0, 2,1,0,0,4);
        applyStimulus(0,0,0,0,0,0, 3,1,0,0,4);
        applyStimulus(0,1,0,1,0,0, 0,0,1,0,5);
        applyStimulus(1,0,0,0,0,0, 0,1,0,0,5);

        // Single mode: IDLE after each instruction, one instruction per run.
        for (int i = 1; i < 8; i++) applyStimulus(0,0,1,0,0,0, i,1,0,0,5);
        applyStimulus(0,0,1,0,0,0, 0,0,0,0,6);
        applyStimulus(0,0,1,0,0,0, 0,0,0,0,6);
        applyStimulus(1,0,1,0,0,0, 0,1,0,0,6);
        for (int i = 1; i < 4; i++) applyStimulus(0,0,1,0,0,0, i,1,0,0,6);
        applyStimulus(0,0,1,1,0,0, 0,0,0,0,7);
        applyStimulus(1,0,0,0,0,0, 0,1,0,0,7);

        // Twelve short instructions carry the 4-bit counter past its wrap.
        for (int k = 0; k < 12; k++) begin
            for (int i = 1; i < 4; i++) applyStimulus(0,0,0,0,0,0, i,1,0,0,7 + k);
            applyStimulus(0,0,0,1,0,0, 0,1,0,0,8 + k);
        end

        // Asynchronous reset in the middle of T5.
        for (int i = 1; i < 6; i++) applyStimulus(0,0,0,0,0,0, i,1,0,0,19);
        @(posedge clk);
        #3;
        clr = 1'b0;
        #1;
        checkOutput(z);
        cmp("midreset_step_idx", {29'd0, step_idx}, 0);
        @(negedge clk);
        clr = 1'b1;
        applyStimulus(1,0,0,0,0,0, 0,1,0,0,0);
        applyStimulus(0,0,0,0,0,0, 1,1,0,0,0);

        @(posedge clk);
        #2;
        cmp("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
